adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; the block SHALL support any WIDTH >= 4 that is a multiple of 4.
REQ-002 Port clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-003 Port rst  input  1  reset; the block SHALL treat it as asynchronous and active-high.
REQ-004 Port in1  input  WIDTH  first unsigned operand.
REQ-005 Port in2  input  WIDTH  second unsigned operand.
REQ-006 Port out  output  WIDTH  registered sum, low WIDTH bits.
REQ-007 Port cout  output  1  registered carry-out of the same sum; may be left unconnected by users.

Function
REQ-008 On every rising clk edge with rst low, the block SHALL sample in1 and in2 and register {cout, out} = in1 + in2, computed as a (WIDTH+1)-bit unsigned sum.
REQ-009 Latency SHALL be exactly one clock: a result is visible on out/cout after the first rising edge at which its operands were sampled, and SHALL be held until the next edge.
REQ-010 The block SHALL be fully pipelined: new operands accepted every cycle; no valid/ready handshake, no stall.
REQ-011 Arithmetic SHALL wrap modulo 2^WIDTH on out; the overflow bit SHALL appear only on cout.
REQ-012 Operands SHALL be treated as unsigned; no sign extension, no saturation.
REQ-013 The sum SHALL be built as a carry-lookahead adder: 4-bit groups with generate/propagate per bit, group G/P, and a second-level lookahead across groups; carry-in to bit 0 fixed at 0.
REQ-014 Combinational path in1/in2 -> register D input SHALL contain no dependence on the previous out value (no accumulation).
REQ-015 Inputs changing between edges SHALL have no effect on out until the next rising edge.
REQ-016 Outputs SHALL never carry X after reset, given known inputs.

Reset
REQ-017 While rst is high, out SHALL be 0 and cout SHALL be 0, independent of clk.
REQ-018 Assertion of rst SHALL clear out/cout immediately (asynchronously), including mid-stream, discarding the in-flight result.
REQ-019 After rst deasserts, the first rising edge SHALL load in1 + in2 normally; no extra idle cycles.

Verification
REQ-020 Reset: rst=1 with in1=5, in2=7, clocking -> out=0, cout=0 throughout.
REQ-021 Basic: in1=0x631, in2=341 (0x155) sampled at an edge -> out=1926 (0x786), cout=0 after that edge.
REQ-022 Zero operand: in1=0o1461 (817), in2=0 -> out=817 one cycle later; back-to-back with REQ-021 stimulus, outputs 1926 then 817 on consecutive cycles.
REQ-023 Overflow: in1=0xFFFFFFFF, in2=1 -> out=0, cout=1; in1=0x80000000, in2=0x80000000 -> out=0, cout=1; in1=0xFFFFFFFF, in2=0xFFFFFFFF -> out=0xFFFFFFFE, cout=1.
REQ-024 Carry chain: in1=0x0000FFFF, in2=1 -> out=0x00010000; in1=0x0FFFFFFF, in2=1 -> out=0x10000000 (cross-group lookahead).
REQ-025 Async reset mid-operation: rst pulsed high between edges while out=0x786 -> out drops to 0 before the next edge; random operand stream of 10,000 cycles compared against (in1+in2) mod 2^33 delayed one cycle.

Source files
------------

// File: rtl/adder.sv
// Registered unsigned adder built from a two-level carry-lookahead tree.
// 4-bit groups produce group generate/propagate; a second level resolves group carries.

module adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g, p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All in-group carries expanded directly from cin; no ripple within the group.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
endmodule

module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             cout
);
  localparam int NG = WIDTH / 4;

  logic [NG-1:0]    gg, gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    adder_cla4 u_cla4 (
      .a  (in1[4*i +: 4]),
      .b  (in2[4*i +: 4]),
      .cin(gc[i]),
      .s  (sum[4*i +: 4]),
      .gg (gg[i]),
      .gp (gp[i])
    );
  end

  // Group carry j = OR over i<j of G[i] & P[i+1..j-1]; carry-in to bit 0 is 0.
  always_comb begin
    gc = '0;
    for (int j = 1; j <= NG; j++) begin
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < j; i++) begin
        logic term;
        term = gg[i];
        for (int k = i + 1; k < j; k++) term = term & gp[k];
        acc = acc | term;
      end
      gc[j] = acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      cout <= 1'b0;
    end else begin
      out  <= sum;
      cout <= gc[NG];
    end
  end
endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corners plus a random stream
// compared against a plain 33-bit arithmetic reference.

module tb_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out;
  logic         cout;

  int errors = 0;
  int checks = 0;

  adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .out (out),
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return s[W:0];
  endfunction

  // Drive at the falling edge, check just after the next rising edge.
  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp);
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    chk(tag, {cout, out}, exp);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   e;
    string        tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    in1 = 32'd5;
    in2 = 32'd7;
    #1;
    chk("rst_async_t0", {cout, out}, 33'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {cout, out}, 33'd0);
    end

    @(negedge clk);
    rst = 1'b0;
    apply("basic", 32'h631, 32'd341, 33'd1926);
    apply("zero_op", 32'd817, 32'd0, 33'd817);

    // Mid-cycle input change must not reach the output.
    @(negedge clk);
    in1 = 32'h1234;
    in2 = 32'h1;
    #2;
    chk("hold_between_edges", {cout, out}, 33'd817);

    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         {1'b1, 32'h0},         "ovf_wrap"};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, {1'b1, 32'h0},         "ovf_msb"};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b1, 32'hFFFF_FFFE}, "ovf_max"};
    vecs[3] = '{32'h0000_FFFF, 32'h1,         {1'b0, 32'h0001_0000}, "chain16"};
    vecs[4] = '{32'h0FFF_FFFF, 32'h1,         {1'b0, 32'h1000_0000}, "chain28"};
    vecs[5] = '{32'h7FFF_FFFF, 32'h1,         {1'b0, 32'h8000_0000}, "chain31"};
    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].e);

    // Asynchronous reset pulse between edges, then normal load on the next edge.
    apply("pre_rst", 32'h631, 32'd341, 33'h786);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_midstream", {cout, out}, 33'd0);
    #1;
    rst = 1'b0;
    in1 = 32'd100;
    in2 = 32'd23;
    @(posedge clk);
    #1;
    chk("post_rst_first", {cout, out}, 33'd123);

    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom();
      case (n % 16)
        0: a = '1;
        1: b = '1;
        2: begin a = '1; b = '1; end
        3: a = 32'h0;
        default: ;
      endcase
      apply("random", a, b, ref_sum(a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
